// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART receive path.
//   uart_byte_t  : one received character
//   UART_NEWLINE : line terminator counted by the receive buffer
// ---------------------------------------------------------------------------
package uart_pkg;

   typedef logic [7:0] uart_byte_t;

   localparam uart_byte_t UART_NEWLINE = 8'h0A;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_if
// Bundles the byte-in strobe, the consumer handshake and the status outputs
// of the receive buffer.
//   master : the environment (UART receiver + consumer)
//            drives in_data, in_valid, out_ready, clear_overflow
//   slave  : the buffer
//            drives out_data, out_valid, count, lines, full, overflow
// ---------------------------------------------------------------------------
interface uart_rx_fifo_if #(
   parameter int DEPTH = 16
);
   import uart_pkg::*;

   localparam int AW = $clog2(DEPTH);

   uart_byte_t  in_data;
   logic        in_valid;
   logic        out_ready;
   logic        clear_overflow;
   uart_byte_t  out_data;
   logic        out_valid;
   logic [AW:0] count;
   logic [AW:0] lines;
   logic        full;
   logic        overflow;

   modport master (
      output in_data, in_valid, out_ready, clear_overflow,
      input  out_data, out_valid, count, lines, full, overflow
   );

   modport slave (
      input  in_data, in_valid, out_ready, clear_overflow,
      output out_data, out_valid, count, lines, full, overflow
   );

endinterface

// File: rtl/uart_fifo_ram.sv
// ---------------------------------------------------------------------------
// uart_fifo_ram
// DEPTH x 8 byte storage for the receive buffer. Synchronous write,
// asynchronous read so the head byte is available in the same cycle.
// Contents are deliberately not reset.
// Ports:
//   clk    in  clock
//   we     in  write enable
//   waddr  in  write address
//   wdata  in  write data
//   raddr  in  read address
//   rdata  out read data (combinational)
// ---------------------------------------------------------------------------
module uart_fifo_ram
   import uart_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  uart_byte_t    wdata,
   input  logic [AW-1:0] raddr,
   output uart_byte_t    rdata
);

   uart_byte_t mem [DEPTH];

   // Write port: one byte per cycle when the buffer accepts a push.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// First-word-fall-through byte buffer behind the UART receiver. Counts held
// bytes and held newline bytes, and raises a sticky overflow flag when a
// byte arrives while full with no pop in the same cycle (that byte is lost).
// Ports:
//   clk  in  clock shared by receiver and consumer
//   rst  in  asynchronous active-high reset
//   bus  slave modport of uart_rx_fifo_if
//        in_data/in_valid     : byte strobe from the receiver
//        out_ready            : consumer takes the head byte
//        out_data/out_valid   : head byte (8'h00 when empty) / non-empty
//        count/lines          : bytes held / newline bytes held
//        full/overflow        : count == DEPTH / sticky drop flag
//        clear_overflow       : clears overflow on the next edge
// ---------------------------------------------------------------------------
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic          clk,
   input  logic          rst,
   uart_rx_fifo_if.slave bus
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]   ONE_COUNT  = (AW+1)'(1);
   localparam logic [AW-1:0] ONE_PTR    = AW'(1);

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count_q;
   logic [AW:0]   lines_q;
   logic          overflow_q;

   logic          full;
   logic          out_valid;
   logic          push;
   logic          pop;
   logic          drop;
   logic          push_nl;
   logic          pop_nl;
   uart_byte_t    head;

   // A pop frees a slot in the same cycle, so a full buffer can still take a
   // byte when the consumer is draining it.
   assign full      = (count_q == FULL_COUNT);
   assign out_valid = (count_q != '0);
   assign pop       = out_valid && bus.out_ready;
   assign push      = bus.in_valid && (!full || pop);
   assign drop      = bus.in_valid && !push;
   assign push_nl   = push && (bus.in_data == UART_NEWLINE);
   assign pop_nl    = pop && (head == UART_NEWLINE);

   uart_fifo_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr),
      .wdata (bus.in_data),
      .raddr (rd_ptr),
      .rdata (head)
   );

   // Pointer, occupancy and line bookkeeping. Pointers wrap naturally at
   // DEPTH; count and lines only move when exactly one side is active.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         lines_q <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + ONE_PTR;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + ONE_PTR;
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + ONE_COUNT;
            2'b01:   count_q <= count_q - ONE_COUNT;
            default: count_q <= count_q;
         endcase
         case ({push_nl, pop_nl})
            2'b10:   lines_q <= lines_q + ONE_COUNT;
            2'b01:   lines_q <= lines_q - ONE_COUNT;
            default: lines_q <= lines_q;
         endcase
      end
   end

   // Sticky overflow: a drop in the same cycle as a clear request wins, so
   // a lost byte is never silently forgotten.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_q <= 1'b0;
      end else if (drop) begin
         overflow_q <= 1'b1;
      end else if (bus.clear_overflow) begin
         overflow_q <= 1'b0;
      end
   end

   assign bus.out_data  = out_valid ? head : 8'h00;
   assign bus.out_valid = out_valid;
   assign bus.count     = count_q;
   assign bus.lines     = lines_q;
   assign bus.full      = full;
   assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
// Bench for uart_rx_fifo (DEPTH = 16). A queue-based reference model of the
// buffer tracks expected contents; directed table vectors, hand-written
// corner sequences and random traffic are checked every cycle.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;
   import uart_pkg::*;

   localparam int DEPTH = 16;

   logic clk;
   logic rst;

   uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

   uart_rx_fifo #(.DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       iv;
      logic [7:0] id;
      logic       rdy;
      logic       clr;
      int         e_count;
      int         e_lines;
      logic       e_valid;
      logic [7:0] e_data;
      logic       e_full;
      logic       e_ovf;
   } vec_t;

   vec_t       vecs[$];
   uart_byte_t model_q[$];
   logic       model_ovf;
   int         vectors;
   int         miscompares;

   // Reference model: the buffer is a queue of bytes; the consumer side is
   // served first so a full buffer can accept a byte while being drained.
   task automatic modelStep(input logic iv, input logic [7:0] id,
                            input logic rdy, input logic clr);
      logic was_full;
      logic did_push;
      was_full = (model_q.size() == DEPTH);
      if (rdy && model_q.size() > 0) begin
         void'(model_q.pop_front());
         did_push = iv;
      end else begin
         did_push = iv && !was_full;
      end
      if (did_push) model_q.push_back(id);
      if (iv && !did_push) model_ovf = 1'b1;
      else if (clr)        model_ovf = 1'b0;
   endtask

   function automatic int modelLines();
      int n;
      n = 0;
      foreach (model_q[i]) if (model_q[i] == UART_NEWLINE) n++;
      return n;
   endfunction

   task automatic checkField(input string tag, input string field,
                             input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("[TB] FAIL %s.%s: got %0h, expected %0h", tag, field, act, exp);
      end
   endtask

   task automatic checkOutput(input string tag, input int ec, input int el,
                              input logic ev, input logic [7:0] ed,
                              input logic ef, input logic eo);
      checkField(tag, "count",     int'(bus.count),     ec);
      checkField(tag, "lines",     int'(bus.lines),     el);
      checkField(tag, "out_valid", int'(bus.out_valid), int'(ev));
      checkField(tag, "out_data",  int'(bus.out_data),  int'(ed));
      checkField(tag, "full",      int'(bus.full),      int'(ef));
      checkField(tag, "overflow",  int'(bus.overflow),  int'(eo));
   endtask

   task automatic checkModel(input string tag);
      int sz;
      sz = model_q.size();
      checkOutput(tag, sz, modelLines(), sz > 0,
                  (sz > 0) ? model_q[0] : 8'h00, sz == DEPTH, model_ovf);
   endtask

   // Drive one cycle of inputs, advance past the edge, update the model.
   task automatic applyStimulus(input logic iv, input logic [7:0] id,
                                input logic rdy, input logic clr);
      bus.in_valid       = iv;
      bus.in_data        = id;
      bus.out_ready      = rdy;
      bus.clear_overflow = clr;
      @(posedge clk);
      modelStep(iv, id, rdy, clr);
      #1;
      bus.in_valid       = 1'b0;
      bus.out_ready      = 1'b0;
      bus.clear_overflow = 1'b0;
   endtask

   function automatic vec_t mkVec(logic iv, logic [7:0] id, logic rdy,
                                  int ec, int el, logic [7:0] ed);
      vec_t v;
      v.iv = iv; v.id = id; v.rdy = rdy; v.clr = 1'b0;
      v.e_count = ec; v.e_lines = el; v.e_valid = (ec > 0);
      v.e_data = ed; v.e_full = 1'b0; v.e_ovf = 1'b0;
      return v;
   endfunction

   task automatic doReset();
      rst = 1'b1;
      model_q.delete();
      model_ovf = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      bus.in_valid       = 1'b0;
      bus.in_data        = 8'h00;
      bus.out_ready      = 1'b0;
      bus.clear_overflow = 1'b0;
      model_ovf = 1'b0;
      doReset();

      // Directed table: expectations written out by hand.
      vecs.push_back(mkVec(0, 8'h00, 0, 0, 0, 8'h00));
      vecs.push_back(mkVec(1, 8'h48, 0, 1, 0, 8'h48));
      vecs.push_back(mkVec(1, 8'h65, 0, 2, 0, 8'h48));
      vecs.push_back(mkVec(1, 8'h6C, 0, 3, 0, 8'h48));
      vecs.push_back(mkVec(0, 8'h00, 1, 2, 0, 8'h65));
      vecs.push_back(mkVec(0, 8'h00, 1, 1, 0, 8'h6C));
      vecs.push_back(mkVec(0, 8'h00, 1, 0, 0, 8'h00));
      vecs.push_back(mkVec(1, 8'h48, 0, 1, 0, 8'h48));
      vecs.push_back(mkVec(1, 8'h69, 0, 2, 0, 8'h48));
      vecs.push_back(mkVec(1, 8'h0A, 0, 3, 1, 8'h48));
      vecs.push_back(mkVec(1, 8'h4F, 0, 4, 1, 8'h48));
      vecs.push_back(mkVec(1, 8'h4B, 0, 5, 1, 8'h48));
      vecs.push_back(mkVec(1, 8'h0A, 0, 6, 2, 8'h48));
      vecs.push_back(mkVec(0, 8'h00, 1, 5, 2, 8'h69));
      vecs.push_back(mkVec(0, 8'h00, 1, 4, 2, 8'h0A));
      vecs.push_back(mkVec(0, 8'h00, 1, 3, 1, 8'h4F));
      vecs.push_back(mkVec(0, 8'h00, 1, 2, 1, 8'h4B));
      vecs.push_back(mkVec(0, 8'h00, 1, 1, 1, 8'h0A));
      vecs.push_back(mkVec(0, 8'h00, 1, 0, 0, 8'h00));
      vecs.push_back(mkVec(1, 8'h55, 1, 1, 0, 8'h55));
      vecs.push_back(mkVec(1, 8'h0A, 1, 1, 1, 8'h0A));
      vecs.push_back(mkVec(1, 8'h0A, 1, 1, 1, 8'h0A));
      vecs.push_back(mkVec(0, 8'h00, 1, 0, 0, 8'h00));

      checkOutput("reset", 0, 0, 1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].iv, vecs[i].id, vecs[i].rdy, vecs[i].clr);
         checkOutput($sformatf("table%0d", i), vecs[i].e_count, vecs[i].e_lines,
                     vecs[i].e_valid, vecs[i].e_data, vecs[i].e_full, vecs[i].e_ovf);
      end

      // Overflow: 17 pushes with no pop; the 17th byte is dropped.
      for (int i = 0; i < 17; i++) begin
         applyStimulus(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
         checkModel($sformatf("fill%0d", i));
      end
      checkOutput("ovf_full", 16, 0, 1'b1, 8'h10, 1'b1, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      checkOutput("ovf_clear", 16, 0, 1'b1, 8'h10, 1'b1, 1'b0);

      // Full with simultaneous push and pop across the pointer wrap.
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b1, 8'(8'hA0 + i), 1'b1, 1'b0);
         checkModel($sformatf("sustain%0d", i));
      end
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
         checkModel($sformatf("drain%0d", i));
      end
      checkOutput("drained", 0, 0, 1'b0, 8'h00, 1'b0, 1'b0);

      // Random traffic, newline-heavy so the line counter gets exercised.
      for (int i = 0; i < 400; i++) begin
         logic [7:0] d;
         d = ($urandom_range(0, 3) == 0) ? UART_NEWLINE : 8'($urandom);
         applyStimulus(1'($urandom_range(0, 2) != 0), d,
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0));
         checkModel($sformatf("rand%0d", i));
      end

      // Mid-operation reset with count=5, lines=1, overflow=1.
      doReset();
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, (i == 15) ? 8'h0A : 8'(8'h30 + i), 1'b0, 1'b0);
      end
      applyStimulus(1'b1, 8'h77, 1'b0, 1'b0);
      for (int i = 0; i < 11; i++) begin
         applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      end
      checkOutput("pre_rst", 5, 1, 1'b1, 8'h3B, 1'b0, 1'b1);
      #1;
      rst = 1'b1;
      model_q.delete();
      model_ovf = 1'b0;
      #1;
      checkOutput("async_rst", 0, 0, 1'b0, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("post_rst", 0, 0, 1'b0, 8'h00, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer that sits directly downstream of the UART receiver. Captures each received byte on the receiver's one-cycle valid strobe and stores it in a first-word-fall-through FIFO for a slower consumer (command parser, LED/debug sink). Counts complete lines (0x0A terminators) held in the buffer so the consumer can wait for a whole line before draining. Reports overflow with a sticky flag; overflowing bytes are dropped.

## Interface
- DEPTH, 16, number of byte slots; power of two, 4..256
- AW, $clog2(DEPTH), pointer width (derived, not overridden)
- clk  in  1  single clock; receiver and consumer share this domain
- rst  in  1  asynchronous, active-high reset
- in_data  in  8  received byte, qualified by in_valid
- in_valid  in  1  one-cycle strobe from the receiver
- out_ready  in  1  consumer accepts the head byte this cycle
- out_data  out  8  head byte; 8'h00 when empty
- out_valid  out  1  FIFO non-empty
- count  out  AW+1  bytes held, 0..DEPTH
- lines  out  AW+1  0x0A bytes currently held, 0..DEPTH
- full  out  1  count == DEPTH
- overflow  out  1  sticky: a byte was dropped
- clear_overflow  in  1  clears overflow on next edge

## Operation
- push = in_valid && (!full || pop); pop = out_valid && out_ready.
- Push writes in_data at wr_ptr and increments wr_ptr (AW bits, natural wrap at DEPTH). Pop increments rd_ptr (same wrap).
- count: +1 on push only, -1 on pop only, unchanged on both or neither.
- Full + in_valid + pop in the same cycle: byte accepted, count stays DEPTH, no overflow.
- Full + in_valid without pop: byte dropped, pointers/count unchanged, overflow set.
- lines: +1 on push of 8'h0A, -1 on pop of head == 8'h0A; both in one cycle leaves it unchanged. Never exceeds count.
- overflow: set takes priority over clear_overflow in the same cycle.
- Empty + in_valid + out_ready: push only (no pop, out_valid was 0); byte appears next cycle.
- out_data = mem[rd_ptr] when out_valid, else 8'h00 (combinational from registered state).
- Memory contents are not reset; every other state element is.

## Timing
- Reset (async assert, release synchronous to clk): wr_ptr=0, rd_ptr=0, count=0, lines=0, overflow=0; hence out_valid=0, out_data=8'h00, full=0.
- Reset mid-operation discards all held bytes immediately; no pop beats are generated.
- Write-to-read latency: byte strobed at edge N is on out_data with out_valid=1 after edge N (visible in cycle N+1).
- Pop takes effect at the edge where out_valid && out_ready; next head (or empty) visible the following cycle.
- Sustained one push + one pop per cycle supported indefinitely at any fill level.
- All outputs are registered state or pure decode of it; no combinational path from in_* or out_ready to any output.

## Structure
- Shared package uart_pkg: typedef logic [7:0] uart_byte_t; localparam uart_byte_t UART_NEWLINE = 8'h0A.
- One sub-module, uart_fifo_ram: DEPTH x 8 storage, synchronous write port (we, waddr, wdata), asynchronous read port (raddr, rdata). Pointer, count, line and flag logic live in uart_rx_fifo.

## Test plan
- Reset then idle -> count=0, lines=0, out_valid=0, out_data=8'h00, full=0, overflow=0.
- Push 0x48,0x65,0x6C (out_ready=0) -> count=3, out_data=0x48; then out_ready=1 for 3 cycles -> out_data 0x48,0x65,0x6C in order, count=0, out_valid=0.
- Push "Hi\n" then "OK\n" -> lines=2, count=6; pop 3 bytes -> lines=1 after the 0x0A leaves.
- DEPTH=16: push 17 bytes, no pop -> full=1, count=16, overflow=1, 17th byte absent when drained; clear_overflow pulse -> overflow=0 next cycle.
- Full FIFO, in_valid and out_ready same cycle for 20 cycles -> count stays 16, overflow stays 0, output order intact across pointer wrap.
- Assert rst with count=5, lines=1, overflow=1 -> all outputs return to reset values before the next clk edge.
